// File: rtl/wishbone_if.sv
// Wishbone B4 classic signal bundle shared by the arbiter's upstream and downstream ports.
interface wishbone_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [3:0]  sel;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [31:0] dat_r;
  logic        ack;

  modport master (
    output cyc, stb, we, sel, adr, dat_w,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, sel, adr, dat_w,
    output dat_r, ack
  );
endinterface

// File: rtl/wishbone_arbiter_2to1.sv
// Two-master Wishbone arbiter: instruction-fetch and load/store masters share one
// downstream bus. Round-robin on ties, grant held for the whole cyc, and a wait
// watchdog that terminates a stalled transfer with an error word.
module wishbone_arbiter_2to1 #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = 32'hFFFF_FFFF
) (
  input  logic       clk,
  input  logic       reset,
  wishbone_if.slave  if_wishbone_slave,
  wishbone_if.slave  lsu_wishbone_slave,
  wishbone_if.master mem_wishbone_master,
  output logic       o_timeout
);

  // Counter value seen during the TIMEOUT-th unanswered strobe cycle.
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    GRANT_IF,
    GRANT_LSU
  } state_t;

  state_t      state;
  state_t      state_next;
  logic        last_lsu;
  logic        last_lsu_next;
  logic [15:0] wait_cnt;

  logic        if_req;
  logic        lsu_req;

  logic        g_cyc;
  logic        g_stb;
  logic        g_we;
  logic [3:0]  g_sel;
  logic [31:0] g_adr;
  logic [31:0] g_dat_w;

  logic        granted;
  logic        ack_ok;
  logic        timeout_hit;
  logic        resp_ack;
  logic [31:0] resp_dat;

  assign if_req  = if_wishbone_slave.cyc  & if_wishbone_slave.stb;
  assign lsu_req = lsu_wishbone_slave.cyc & lsu_wishbone_slave.stb;

  // State register and last-granted pointer (IF counts as last after reset)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      last_lsu <= 1'b0;
    end else begin
      state    <= state_next;
      last_lsu <= last_lsu_next;
    end
  end

  // Next-state selection and mux of the granted master's request signals
  always_comb begin
    state_next    = state;
    last_lsu_next = last_lsu;
    g_cyc         = 1'b0;
    g_stb         = 1'b0;
    g_we          = 1'b0;
    g_sel         = '0;
    g_adr         = '0;
    g_dat_w       = '0;
    case (state)
      IDLE: begin
        if (if_req && lsu_req) begin
          state_next = last_lsu ? GRANT_IF : GRANT_LSU;
        end else if (if_req) begin
          state_next = GRANT_IF;
        end else if (lsu_req) begin
          state_next = GRANT_LSU;
        end
      end
      GRANT_IF: begin
        g_cyc   = if_wishbone_slave.cyc;
        g_stb   = if_wishbone_slave.cyc & if_wishbone_slave.stb;
        g_we    = if_wishbone_slave.we;
        g_sel   = if_wishbone_slave.sel;
        g_adr   = if_wishbone_slave.adr;
        g_dat_w = if_wishbone_slave.dat_w;
        if (!if_wishbone_slave.cyc) begin
          state_next    = IDLE;
          last_lsu_next = 1'b0;
        end
      end
      GRANT_LSU: begin
        g_cyc   = lsu_wishbone_slave.cyc;
        g_stb   = lsu_wishbone_slave.cyc & lsu_wishbone_slave.stb;
        g_we    = lsu_wishbone_slave.we;
        g_sel   = lsu_wishbone_slave.sel;
        g_adr   = lsu_wishbone_slave.adr;
        g_dat_w = lsu_wishbone_slave.dat_w;
        if (!lsu_wishbone_slave.cyc) begin
          state_next    = IDLE;
          last_lsu_next = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Downstream drive, watchdog detection and response steering to the granted master
  always_comb begin
    granted     = (state != IDLE);
    // Acks outside a strobed grant are dropped, including stale acks after reset.
    ack_ok      = granted & g_stb & mem_wishbone_master.ack;
    // A real ack on the limit cycle wins over the watchdog.
    timeout_hit = granted & g_stb & ~mem_wishbone_master.ack & (wait_cnt == WAIT_LAST);
    resp_ack    = ack_ok | timeout_hit;
    resp_dat    = timeout_hit ? ERR_DATA : mem_wishbone_master.dat_r;

    mem_wishbone_master.cyc   = g_cyc;
    mem_wishbone_master.stb   = g_stb & ~timeout_hit;
    mem_wishbone_master.we    = g_we;
    mem_wishbone_master.sel   = g_sel;
    mem_wishbone_master.adr   = g_adr;
    mem_wishbone_master.dat_w = g_dat_w;

    if_wishbone_slave.ack    = 1'b0;
    if_wishbone_slave.dat_r  = '0;
    lsu_wishbone_slave.ack   = 1'b0;
    lsu_wishbone_slave.dat_r = '0;
    if (state == GRANT_IF) begin
      if_wishbone_slave.ack   = resp_ack;
      if_wishbone_slave.dat_r = resp_dat;
    end
    if (state == GRANT_LSU) begin
      lsu_wishbone_slave.ack   = resp_ack;
      lsu_wishbone_slave.dat_r = resp_dat;
    end
  end

  // Wait counter: idle clears it (so every grant starts at zero), acks and timeouts clear it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wait_cnt <= '0;
    end else if (!granted || ack_ok || timeout_hit) begin
      wait_cnt <= '0;
    end else if (g_stb) begin
      wait_cnt <= wait_cnt + 16'd1;
    end
  end

  // Sticky timeout flag, cleared only by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      o_timeout <= 1'b0;
    end else if (timeout_hit) begin
      o_timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_wishbone_arbiter_2to1.sv
// Directed bench for the 2:1 Wishbone arbiter with a response scoreboard.
module tb_wishbone_arbiter_2to1;

  logic clk = 1'b0;
  logic reset;
  logic o_timeout;

  wishbone_if if_bus ();
  wishbone_if lsu_bus ();
  wishbone_if mem_bus ();

  int unsigned tests = 0;
  int unsigned fails = 0;

  typedef struct {
    string       tag;
    logic        who;   // 0 = IF, 1 = LSU
    logic [31:0] dat;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  wishbone_arbiter_2to1 #(
    .TIMEOUT (4),
    .ERR_DATA(32'hFFFF_FFFF)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .if_wishbone_slave  (if_bus),
    .lsu_wishbone_slave (lsu_bus),
    .mem_wishbone_master(mem_bus),
    .o_timeout          (o_timeout)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic who, input logic [31:0] dat);
    exp_t e;
    e.tag = tag;
    e.who = who;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Any upstream ack pops the oldest expectation and is compared against it.
  task automatic sample();
    exp_t e;
    if (if_bus.ack || lsu_bus.ack) begin
      if (sb.size() == 0) begin
        check("unexpected_ack", 32'({if_bus.ack, lsu_bus.ack}), 32'd0);
      end else begin
        e = sb.pop_front();
        check($sformatf("%s_who", e.tag), 32'({if_bus.ack, lsu_bus.ack}),
              e.who ? 32'd1 : 32'd2);
        check($sformatf("%s_dat", e.tag), e.who ? lsu_bus.dat_r : if_bus.dat_r, e.dat);
      end
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    sample();
  endtask

  task automatic to_pos();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_if(input logic c, input logic s, input logic w, input logic [3:0] se,
                          input logic [31:0] a, input logic [31:0] d);
    if_bus.cyc = c; if_bus.stb = s; if_bus.we = w;
    if_bus.sel = se; if_bus.adr = a; if_bus.dat_w = d;
  endtask

  task automatic drive_lsu(input logic c, input logic s, input logic w, input logic [3:0] se,
                           input logic [31:0] a, input logic [31:0] d);
    lsu_bus.cyc = c; lsu_bus.stb = s; lsu_bus.we = w;
    lsu_bus.sel = se; lsu_bus.adr = a; lsu_bus.dat_w = d;
  endtask

  task automatic drive_mem(input logic a, input logic [31:0] d);
    mem_bus.ack   = a;
    mem_bus.dat_r = d;
  endtask

  initial begin
    reset = 1'b1;
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    to_pos();

    // Reset: a request and a stray ack must both be blocked.
    drive_if(1, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
    drive_mem(1, 32'hDEAD_0000);
    at_neg();
    check("rst_mem_cyc", 32'(mem_bus.cyc), 32'd0);
    check("rst_mem_adr", mem_bus.adr, 32'd0);
    check("rst_if_ack", 32'(if_bus.ack), 32'd0);
    check("rst_timeout", 32'(o_timeout), 32'd0);
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    reset = 1'b0;

    // Simultaneous requests out of reset: LSU first, one idle cycle, then IF.
    drive_if(1, 1, 0, 4'hF, 32'h0000_0200, 32'h0);
    drive_lsu(1, 1, 0, 4'hF, 32'h0000_0300, 32'h0);
    at_neg();
    check("tie_idle_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    at_neg();
    check("tie_lsu_first", mem_bus.adr, 32'h0000_0300);
    to_pos();
    drive_mem(1, 32'h0000_0011);
    push("tie_lsu", 1'b1, 32'h0000_0011);
    at_neg();
    check("nongrant_if_ack", 32'(if_bus.ack), 32'd0);
    check("nongrant_if_dat", if_bus.dat_r, 32'd0);
    to_pos();
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    check("lsu_release_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    at_neg();
    check("gap_idle_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    at_neg();
    check("if_after_lsu", mem_bus.adr, 32'h0000_0200);
    to_pos();
    drive_mem(1, 32'h0000_0022);
    push("tie_if", 1'b0, 32'h0000_0022);
    at_neg();
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    to_pos();

    // IF-only read, two wait cycles, ack on the third granted cycle.
    drive_if(1, 1, 0, 4'hF, 32'h0000_0100, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    check("rd_adr", mem_bus.adr, 32'h0000_0100);
    check("rd_stb", 32'(mem_bus.stb), 32'd1);
    check("rd_wait1_ack", 32'(if_bus.ack), 32'd0);
    to_pos();
    at_neg();
    check("rd_wait2_ack", 32'(if_bus.ack), 32'd0);
    to_pos();
    drive_mem(1, 32'h0000_0013);
    push("rd_if", 1'b0, 32'h0000_0013);
    at_neg();
    check("rd_lsu_ack", 32'(lsu_bus.ack), 32'd0);
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    to_pos();

    // LSU write, IF arrives mid-transfer and is held off across two beats.
    drive_lsu(1, 1, 1, 4'hF, 32'h1000_0004, 32'hCAFE_BABE);
    at_neg();
    to_pos();
    drive_if(1, 1, 0, 4'hF, 32'h0000_0400, 32'h0);
    at_neg();
    check("wr_adr", mem_bus.adr, 32'h1000_0004);
    check("wr_dat", mem_bus.dat_w, 32'hCAFE_BABE);
    check("wr_sel", 32'(mem_bus.sel), 32'hF);
    check("wr_we", 32'(mem_bus.we), 32'd1);
    to_pos();
    at_neg();
    check("wr_if_held", mem_bus.adr, 32'h1000_0004);
    check("wr_if_held_ack", 32'(if_bus.ack), 32'd0);
    to_pos();
    drive_mem(1, 32'h0);
    push("wr_beat1", 1'b1, 32'h0);
    at_neg();
    to_pos();
    drive_lsu(1, 1, 1, 4'hF, 32'h1000_0008, 32'h1234_5678);
    push("wr_beat2", 1'b1, 32'h0);
    at_neg();
    check("wr_beat2_adr", mem_bus.adr, 32'h1000_0008);
    to_pos();
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    check("wr_release_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    at_neg();
    check("wr_gap_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    at_neg();
    check("wr_if_granted", mem_bus.adr, 32'h0000_0400);
    to_pos();
    drive_mem(1, 32'h0000_0044);
    push("wr_if_read", 1'b0, 32'h0000_0044);
    at_neg();
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    to_pos();

    // Ack while idle is not forwarded.
    drive_mem(1, 32'h0000_0055);
    at_neg();
    check("idle_ack_ignored", 32'({if_bus.ack, lsu_bus.ack}), 32'd0);
    to_pos();
    drive_mem(0, 32'h0);

    // Ack on the 4th strobed wait cycle wins over the watchdog; a strobe-low cycle does not count.
    drive_if(1, 1, 0, 4'hF, 32'h0000_0500, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    to_pos();
    drive_if(1, 0, 0, 4'hF, 32'h0000_0500, 32'h0);
    drive_mem(1, 32'h0000_0066);
    at_neg();
    check("stb_low_ack_ignored", 32'(if_bus.ack), 32'd0);
    to_pos();
    drive_if(1, 1, 0, 4'hF, 32'h0000_0500, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    to_pos();
    drive_mem(1, 32'h0000_0029);
    push("limit_ack", 1'b0, 32'h0000_0029);
    at_neg();
    check("limit_stb_kept", 32'(mem_bus.stb), 32'd1);
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    check("limit_no_timeout", 32'(o_timeout), 32'd0);
    to_pos();

    // Slave never answers: error response on the 4th wait cycle, sticky flag.
    drive_lsu(1, 1, 0, 4'hF, 32'h0000_0600, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    check("to_wait1_ack", 32'(lsu_bus.ack), 32'd0);
    to_pos();
    at_neg();
    to_pos();
    at_neg();
    check("to_wait3_stb", 32'(mem_bus.stb), 32'd1);
    to_pos();
    push("to_err", 1'b1, 32'hFFFF_FFFF);
    at_neg();
    check("to_stb_dropped", 32'(mem_bus.stb), 32'd0);
    check("to_cyc_kept", 32'(mem_bus.cyc), 32'd1);
    to_pos();
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    at_neg();
    check("to_flag_set", 32'(o_timeout), 32'd1);
    to_pos();
    at_neg();
    to_pos();
    at_neg();
    check("to_flag_sticky", 32'(o_timeout), 32'd1);
    to_pos();

    // Reset in the middle of a granted LSU read, slave acks afterwards.
    drive_lsu(1, 1, 0, 4'hF, 32'h0000_0700, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    check("mid_granted", 32'(mem_bus.cyc), 32'd1);
    to_pos();
    reset = 1'b1;
    #1;
    check("mid_rst_async_cyc", 32'(mem_bus.cyc), 32'd0);
    to_pos();
    drive_mem(1, 32'h0000_0030);
    at_neg();
    check("mid_rst_lsu_ack", 32'(lsu_bus.ack), 32'd0);
    check("mid_rst_if_ack", 32'(if_bus.ack), 32'd0);
    check("mid_rst_mem_stb", 32'(mem_bus.stb), 32'd0);
    check("mid_rst_mem_adr", mem_bus.adr, 32'd0);
    check("mid_rst_timeout_clr", 32'(o_timeout), 32'd0);
    to_pos();
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    reset = 1'b0;
    at_neg();
    check("late_ack_after_rst", 32'(lsu_bus.ack), 32'd0);
    to_pos();
    drive_mem(0, 32'h0);

    // Reset restored the last-granted pointer to IF, so LSU wins this tie again.
    drive_if(1, 1, 0, 4'hF, 32'h0000_0800, 32'h0);
    drive_lsu(1, 1, 0, 4'hF, 32'h0000_0900, 32'h0);
    at_neg();
    to_pos();
    at_neg();
    check("rst_tie_lsu", mem_bus.adr, 32'h0000_0900);
    to_pos();
    drive_mem(1, 32'h0000_0088);
    push("rst_tie_read", 1'b1, 32'h0000_0088);
    at_neg();
    to_pos();
    drive_if(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_lsu(0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive_mem(0, 32'h0);
    at_neg();
    to_pos();
    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wishbone_arbiter_2to1.md
WISHBONE_ARBITER_2TO1 -- requirements
Module: wishbone_arbiter_2to1

Interface
REQ-001 Parameter TIMEOUT, default 255: max cycles a granted transfer waits for slave ack before forced termination; legal range 1..65535.
REQ-002 Parameter ERR_DATA, default 32'hFFFF_FFFF: read data returned to a master on a timed-out transfer.
REQ-003 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-high reset.
REQ-005 Port if_wishbone_slave  wishbone_if.slave  -  instruction-fetch master side (cyc, stb, we, sel[3:0], adr[31:0], dat_w[31:0], dat_r[31:0], ack).
REQ-006 Port lsu_wishbone_slave  wishbone_if.slave  -  load/store master side, same signal set.
REQ-007 Port mem_wishbone_master  wishbone_if.master  -  single shared downstream bus, same signal set.
REQ-008 Port o_timeout  output  1  sticky flag, set when any transfer is forcibly terminated.

Function
REQ-009 The block SHALL implement states IDLE, GRANT_IF, GRANT_LSU.
REQ-010 IDLE: if exactly one master asserts cyc&stb, the block SHALL enter that master's GRANT state next cycle.
REQ-011 IDLE with both requesting: the block SHALL grant the master NOT granted last (round-robin); after reset the last-granted pointer SHALL be IF, so LSU wins the first tie.
REQ-012 Downstream cyc, stb, we, sel, adr, dat_w SHALL combinationally follow the granted master in a GRANT state and SHALL be 0 in IDLE.
REQ-013 Downstream ack and dat_r SHALL be routed only to the granted master; the non-granted master SHALL see ack=0 and dat_r=0.
REQ-014 A GRANT state SHALL be held while the granted master holds cyc, including across multiple ack'd beats; grant changes only via IDLE.
REQ-015 When the granted master drops cyc, the block SHALL return to IDLE next cycle and update the last-granted pointer; minimum one idle cycle between grants.
REQ-016 A 16-bit wait counter SHALL clear on grant entry and on each downstream ack, and increment each GRANT cycle with stb high and ack low.
REQ-017 When the counter reaches TIMEOUT with no ack, the block SHALL drive ack=1 and dat_r=ERR_DATA to the granted master for exactly one cycle, deassert downstream stb that cycle, set o_timeout, and clear the counter.
REQ-018 A downstream ack in the same cycle as the counter reaching TIMEOUT SHALL take precedence (normal data, no timeout, o_timeout unchanged).
REQ-019 A downstream ack arriving in IDLE or while stb is low SHALL be ignored and not forwarded.
REQ-020 o_timeout SHALL stay set until reset.
REQ-021 Latency: zero added cycles on data/ack paths; grant latency one cycle from request in IDLE.

Reset
REQ-022 On reset assertion the block SHALL immediately enter IDLE, clear wait counter and o_timeout, set last-granted=IF, and drive all downstream outputs and upstream acks to 0.
REQ-023 Reset asserted mid-transfer SHALL abort the transfer with no ack to either master; a late downstream ack after reset SHALL be ignored.
REQ-024 After reset deassertion, the first grant SHALL occur no earlier than the first rising edge with a request present.

Verification
REQ-025 IF-only read adr=0x0000_0100, slave acks after 2 wait cycles with 0x0000_0013 -> IF sees ack on cycle 3 after grant with dat_r=0x0000_0013; LSU ack stays 0.
REQ-026 IF and LSU request simultaneously out of reset -> LSU granted first; after LSU drops cyc, one IDLE cycle, then IF granted.
REQ-027 LSU write adr=0x1000_0004 dat_w=0xCAFEBABE sel=4'b1111 -> downstream sees identical adr/dat_w/sel/we=1; IF held off until LSU releases cyc.
REQ-028 TIMEOUT=4, slave never acks -> granted master receives ack with dat_r=0xFFFF_FFFF on 4th wait cycle, o_timeout=1 and stays 1.
REQ-029 TIMEOUT=4, slave acks on exactly the 4th wait cycle -> normal data delivered, o_timeout remains 0.
REQ-030 Reset pulsed during granted LSU read, slave acks one cycle later -> no ack reaches either master, state IDLE, all outputs 0.
